// File: rtl/octree_cmd_pkg.sv
// Shared op codes, Octree control codes and the command-master state encoding.
package octree_cmd_pkg;

  localparam logic [1:0] OP_NOP    = 2'b00;
  localparam logic [1:0] OP_SEARCH = 2'b01;
  localparam logic [1:0] OP_ADD    = 2'b10;
  localparam logic [1:0] OP_DEL    = 2'b11;

  localparam logic [2:0] CTRL_IDLE   = 3'b000;
  localparam logic [2:0] CTRL_SEARCH = 3'b001;
  localparam logic [2:0] CTRL_ADD    = 3'b010;
  localparam logic [2:0] CTRL_DEL    = 3'b011;

  typedef enum logic [3:0] {
    IDLE      = 4'd0,
    LOAD      = 4'd1,
    STREAM    = 4'd2,
    ISSUE     = 4'd3,
    WAIT_RDY  = 4'd4,
    PULSE     = 4'd5,
    WAIT_DONE = 4'd6,
    RESP      = 4'd7,
    GAP       = 4'd8
  } state_e;

  function automatic logic [2:0] op_to_ctrl(input logic [1:0] op);
    case (op)
      OP_SEARCH: return CTRL_SEARCH;
      OP_ADD:    return CTRL_ADD;
      OP_DEL:    return CTRL_DEL;
      default:   return CTRL_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/octree_feat_buf.sv
// Feature word buffer for add commands: filled word by word, then replayed in order.
module octree_feat_buf #(
  parameter int DATA_BUS_WIDTH = 64,
  parameter int FEATURE_LENTH  = 9
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      clr_i,
  input  logic                      wr_en_i,
  input  logic [DATA_BUS_WIDTH-1:0] wr_data_i,
  input  logic                      rd_en_i,
  output logic [DATA_BUS_WIDTH-1:0] rd_data_o,
  output logic                      wr_last_o,
  output logic                      rd_done_o
);

  localparam int IW = $clog2(FEATURE_LENTH + 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(FEATURE_LENTH - 1);
  localparam logic [IW-1:0] LEN_IDX  = IW'(FEATURE_LENTH);

  logic [DATA_BUS_WIDTH-1:0] mem_q [FEATURE_LENTH];
  logic [IW-1:0]             wr_idx_q;
  logic [IW-1:0]             rd_idx_q;

  // Write/read index counters; both saturate at the buffer length.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_idx_q <= '0;
      rd_idx_q <= '0;
    end else if (clr_i) begin
      wr_idx_q <= '0;
      rd_idx_q <= '0;
    end else begin
      if (wr_en_i && (wr_idx_q != LEN_IDX)) wr_idx_q <= wr_idx_q + IW'(1);
      if (rd_en_i && (rd_idx_q != LEN_IDX)) rd_idx_q <= rd_idx_q + IW'(1);
    end
  end

  // Storage needs no reset: every word is written before it is replayed.
  always_ff @(posedge clk) begin
    if (wr_en_i && (wr_idx_q < LEN_IDX)) mem_q[wr_idx_q] <= wr_data_i;
  end

  always_comb begin
    rd_data_o = '0;
    if (rd_idx_q < LEN_IDX) rd_data_o = mem_q[rd_idx_q];
    else                    rd_data_o = '0;
  end

  assign wr_last_o = (wr_idx_q == LAST_IDX);
  assign rd_done_o = (rd_idx_q == LEN_IDX);

endmodule

// File: rtl/octree_cmd_master.sv
// Host-command front end for the Octree engine: sequences search/add/delete
// through the Octree ctrl interface and returns one response per command.
module octree_cmd_master
  import octree_cmd_pkg::*;
#(
  parameter int DATA_WIDTH        = 16,
  parameter int DATA_BUS_WIDTH    = 64,
  parameter int DIMENTION         = 3,
  parameter int CONTROL_WIDTH     = 3,
  parameter int COUNTER_WIDTH     = 4,
  parameter int ENCODE_ADDR_WIDTH = 18,
  parameter int FEATURE_LENTH     = 9,
  parameter int TIMEOUT_CYCLES    = 4096
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            cmd_valid,
  output logic                            cmd_ready,
  input  logic [1:0]                      cmd_op,
  input  logic [ENCODE_ADDR_WIDTH-1:0]    cmd_pos,
  input  logic [COUNTER_WIDTH-1:0]        cmd_tree,
  input  logic [DIMENTION*DATA_WIDTH-1:0] cmd_cam,
  input  logic [DATA_WIDTH-1:0]           cmd_dist,
  input  logic [DATA_WIDTH-1:0]           cmd_s,
  input  logic                            feat_valid,
  output logic                            feat_ready,
  input  logic [DATA_BUS_WIDTH-1:0]       feat_data,
  output logic                            rsp_valid,
  input  logic                            rsp_ready,
  output logic                            rsp_err,
  output logic [DATA_BUS_WIDTH-1:0]       rsp_feature,
  output logic [CONTROL_WIDTH-1:0]        ctrl,
  output logic [ENCODE_ADDR_WIDTH-1:0]    pos_encode,
  output logic [COUNTER_WIDTH-1:0]        tree_num,
  output logic [DIMENTION*DATA_WIDTH-1:0] cam_pos,
  output logic [DATA_WIDTH-1:0]           dist_max,
  output logic [DATA_WIDTH-1:0]           s,
  output logic [DATA_BUS_WIDTH-1:0]       feature_in,
  output logic                            out_valid,
  input  logic                            out_ready,
  input  logic [DATA_BUS_WIDTH-1:0]       feature_out,
  input  logic                            search_done,
  input  logic                            del_done,
  input  logic                            add_done
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  state_e                            state_q, state_d;
  logic [1:0]                        op_q, op_nx;
  logic [TW-1:0]                     tmo_q;
  logic                              cmd_ready_q, feat_ready_q, out_valid_q;
  logic                              rsp_valid_q, rsp_err_q;
  logic [DATA_BUS_WIDTH-1:0]         rsp_feature_q, feature_in_q;
  logic [CONTROL_WIDTH-1:0]          ctrl_q;
  logic [ENCODE_ADDR_WIDTH-1:0]      pos_q;
  logic [COUNTER_WIDTH-1:0]          tree_q;
  logic [DIMENTION*DATA_WIDTH-1:0]   cam_q;
  logic [DATA_WIDTH-1:0]             dist_q, s_q;

  logic                              cmd_acc_s, feat_acc_s, tmo_hit_s, done_hit_s;
  logic                              err_s;
  logic [DATA_BUS_WIDTH-1:0]         feat_s;
  logic [2:0]                        ctrl_nx;
  logic                              buf_wr_last, buf_rd_done;
  logic [DATA_BUS_WIDTH-1:0]         buf_rd_data;

  octree_feat_buf #(
    .DATA_BUS_WIDTH (DATA_BUS_WIDTH),
    .FEATURE_LENTH  (FEATURE_LENTH)
  ) u_feat_buf (
    .clk       (clk),
    .rst       (rst),
    .clr_i     (state_q == IDLE),
    .wr_en_i   (feat_acc_s),
    .wr_data_i (feat_data),
    .rd_en_i   (state_d == STREAM),
    .rd_data_o (buf_rd_data),
    .wr_last_o (buf_wr_last),
    .rd_done_o (buf_rd_done)
  );

  assign cmd_acc_s  = (state_q == IDLE) && cmd_valid && cmd_ready_q;
  assign feat_acc_s = (state_q == LOAD) && feat_valid && feat_ready_q;
  assign tmo_hit_s  = (tmo_q == TMO_LAST);
  assign op_nx      = cmd_acc_s ? cmd_op : op_q;

  always_comb begin
    done_hit_s = 1'b0;
    case (op_q)
      OP_SEARCH: done_hit_s = search_done;
      OP_ADD:    done_hit_s = add_done;
      OP_DEL:    done_hit_s = del_done;
      default:   done_hit_s = 1'b0;
    endcase
  end

  // Next-state decode plus the error/feature value captured on entry to RESP.
  always_comb begin
    state_d = state_q;
    err_s   = 1'b0;
    feat_s  = '0;
    case (state_q)
      IDLE: begin
        if (cmd_acc_s) begin
          case (cmd_op)
            OP_ADD:            state_d = LOAD;
            OP_SEARCH, OP_DEL: state_d = ISSUE;
            default: begin
              state_d = RESP;
              err_s   = 1'b1;
            end
          endcase
        end else begin
          state_d = IDLE;
        end
      end
      LOAD:   if (feat_acc_s && buf_wr_last) state_d = STREAM; else state_d = LOAD;
      STREAM: if (buf_rd_done) state_d = WAIT_DONE; else state_d = STREAM;
      ISSUE:  state_d = (op_q == OP_SEARCH) ? WAIT_RDY : WAIT_DONE;
      WAIT_RDY: begin
        if (out_ready) begin
          state_d = PULSE;
        end else if (tmo_hit_s) begin
          state_d = RESP;
          err_s   = 1'b1;
        end else begin
          state_d = WAIT_RDY;
        end
      end
      PULSE: state_d = WAIT_DONE;
      WAIT_DONE: begin
        // A real completion wins over a timeout landing on the same cycle.
        if (done_hit_s) begin
          state_d = RESP;
          feat_s  = (op_q == OP_SEARCH) ? feature_out : '0;
        end else if (tmo_hit_s) begin
          state_d = RESP;
          err_s   = 1'b1;
        end else begin
          state_d = WAIT_DONE;
        end
      end
      RESP:    if (rsp_ready) state_d = GAP; else state_d = RESP;
      GAP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ctrl_nx = CTRL_IDLE;
    case (state_d)
      STREAM:                           ctrl_nx = CTRL_ADD;
      ISSUE, WAIT_RDY, PULSE, WAIT_DONE: ctrl_nx = op_to_ctrl(op_nx);
      default:                          ctrl_nx = CTRL_IDLE;
    endcase
  end

  // State register and all host/Octree outputs, registered from the next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      op_q          <= OP_NOP;
      tmo_q         <= '0;
      cmd_ready_q   <= 1'b0;
      feat_ready_q  <= 1'b0;
      out_valid_q   <= 1'b0;
      ctrl_q        <= '0;
      feature_in_q  <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_err_q     <= 1'b0;
      rsp_feature_q <= '0;
      pos_q         <= '0;
      tree_q        <= '0;
      cam_q         <= '0;
      dist_q        <= '0;
      s_q           <= '0;
    end else begin
      state_q      <= state_d;
      cmd_ready_q  <= (state_d == IDLE);
      feat_ready_q <= (state_d == LOAD);
      out_valid_q  <= (state_d == PULSE);
      ctrl_q       <= CONTROL_WIDTH'(ctrl_nx);
      feature_in_q <= (state_d == STREAM) ? buf_rd_data : '0;
      // Counts consecutive cycles in a wait state; any state change restarts it.
      if (((state_d == WAIT_RDY) || (state_d == WAIT_DONE)) && (state_d == state_q))
        tmo_q <= tmo_q + TW'(1);
      else
        tmo_q <= '0;
      if (cmd_acc_s) begin
        op_q   <= cmd_op;
        pos_q  <= cmd_pos;
        tree_q <= cmd_tree;
        cam_q  <= cmd_cam;
        dist_q <= cmd_dist;
        s_q    <= cmd_s;
      end else if (state_d == IDLE) begin
        op_q   <= OP_NOP;
        pos_q  <= '0;
        tree_q <= '0;
        cam_q  <= '0;
        dist_q <= '0;
        s_q    <= '0;
      end else begin
        op_q <= op_q;
      end
      if ((state_d == RESP) && (state_q != RESP)) begin
        rsp_valid_q   <= 1'b1;
        rsp_err_q     <= err_s;
        rsp_feature_q <= feat_s;
      end else if (state_d != RESP) begin
        rsp_valid_q   <= 1'b0;
        rsp_err_q     <= 1'b0;
        rsp_feature_q <= '0;
      end else begin
        rsp_valid_q <= rsp_valid_q;
      end
    end
  end

  assign cmd_ready   = cmd_ready_q;
  assign feat_ready  = feat_ready_q;
  assign out_valid   = out_valid_q;
  assign ctrl        = ctrl_q;
  assign feature_in  = feature_in_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_err     = rsp_err_q;
  assign rsp_feature = rsp_feature_q;
  assign pos_encode  = pos_q;
  assign tree_num    = tree_q;
  assign cam_pos     = cam_q;
  assign dist_max    = dist_q;
  assign s           = s_q;

endmodule

// File: doc/octree_cmd_master.md
OCTREE_CMD_MASTER -- requirements
Module: octree_cmd_master

Interface
REQ-001 Parameter DATA_WIDTH, default 16, scalar width of cam_pos components, dist_max, s.
REQ-002 Parameter DATA_BUS_WIDTH, default 64, feature word width.
REQ-003 Parameter DIMENTION, default 3, cam_pos component count.
REQ-004 Parameter CONTROL_WIDTH, default 3, Octree ctrl width.
REQ-005 Parameter COUNTER_WIDTH, default 4, tree_num width.
REQ-006 Parameter ENCODE_ADDR_WIDTH, default 18, pos_encode width.
REQ-007 Parameter FEATURE_LENTH, default 9, feature words per node.
REQ-008 Parameter TIMEOUT_CYCLES, default 4096, done-wait limit.
REQ-009 Ports: clk  in  1  clock; rst  in  1  asynchronous active-high reset; one clock, all logic on rising clk.
REQ-010 cmd_valid in 1, cmd_ready out 1, cmd_op in 2 (01 search, 10 add, 11 delete), cmd_pos in ENCODE_ADDR_WIDTH, cmd_tree in COUNTER_WIDTH, cmd_cam in DIMENTION*DATA_WIDTH, cmd_dist in DATA_WIDTH, cmd_s in DATA_WIDTH: host command channel.
REQ-011 feat_valid in 1, feat_ready out 1, feat_data in DATA_BUS_WIDTH: host add-feature channel.
REQ-012 rsp_valid out 1, rsp_ready in 1, rsp_err out 1, rsp_feature out DATA_BUS_WIDTH: host response channel.
REQ-013 Octree side outputs: ctrl CONTROL_WIDTH, pos_encode, tree_num, cam_pos, dist_max, s, feature_in DATA_BUS_WIDTH, out_valid 1; inputs: out_ready 1, feature_out DATA_BUS_WIDTH, search_done, del_done, add_done (1 each).

Function
REQ-014 Handshakes SHALL transfer on valid&&ready at rising clk; rsp_* SHALL hold stable while rsp_valid&&!rsp_ready.
REQ-015 FSM states SHALL be IDLE, LOAD, STREAM, ISSUE, WAIT_RDY, PULSE, WAIT_DONE, RESP, GAP.
REQ-016 IDLE: cmd_ready=1, ctrl=000; on accept latch descriptor; op 10 -> LOAD, 01/11 -> ISSUE, 00 -> RESP with rsp_err=1.
REQ-017 LOAD: feat_ready=1; accept exactly FEATURE_LENTH words into buffer index 0..8; after 9th accept -> STREAM.
REQ-018 STREAM: ctrl=010, feature_in=buf[i] for i=0..8 on 9 consecutive cycles, then -> WAIT_DONE.
REQ-019 ISSUE: one cycle ctrl=001 (search) -> WAIT_RDY, or ctrl=011 (delete) -> WAIT_DONE.
REQ-020 WAIT_RDY: ctrl held 001; on out_ready=1 -> PULSE; PULSE drives out_valid=1 for exactly one cycle -> WAIT_DONE.
REQ-021 WAIT_DONE: ctrl held at command code; on matching done (search_done/add_done/del_done) -> RESP, capturing feature_out into rsp_feature for search, zero otherwise; non-matching dones ignored.
REQ-022 Timeout counter SHALL clear on entry to WAIT_RDY/WAIT_DONE and, after TIMEOUT_CYCLES cycles without exit, force RESP with rsp_err=1, rsp_feature=0.
REQ-023 RESP: ctrl=000, rsp_valid=1 until rsp_ready -> GAP; GAP: one cycle ctrl=000, cmd_ready=0 -> IDLE.
REQ-024 pos_encode, tree_num, cam_pos, dist_max, s SHALL be driven from latched descriptor from accept until GAP exit.
REQ-025 Outputs other than in STREAM: feature_in=0; out_valid=0 outside PULSE.

Reset
REQ-026 rst=1 SHALL immediately force IDLE, all outputs zero (cmd_ready=0 while rst asserted, 1 the first cycle after), buffer index and timeout counter zero, at any state including mid-STREAM.
REQ-027 Buffer contents SHALL NOT require reset.

Structure
REQ-028 Package octree_cmd_pkg SHALL hold op codes, ctrl codes (000/001/010/011), and FSM state enum.
REQ-029 Sub-module octree_feat_buf SHALL hold the FEATURE_LENTH x DATA_BUS_WIDTH buffer with write/read index counters.

Verification
REQ-030 Search, cmd_pos=18'h0_1A2B, out_ready at +5 cycles, search_done at +20 with feature_out=64'hDEAD_BEEF -> ctrl 001, single out_valid pulse, rsp_feature=64'hDEAD_BEEF, rsp_err=0.
REQ-031 Add with words 0..8 (feat_valid gapped every other cycle) -> ctrl 010 with feature_in 0..8 on 9 consecutive cycles, rsp after add_done.
REQ-032 Delete, del_done never asserted, TIMEOUT_CYCLES=16 -> rsp_err=1 exactly 16 cycles after WAIT_DONE entry.
REQ-033 rsp_ready held low 10 cycles -> rsp_valid and rsp_feature stable, then GAP one cycle ctrl=000 before cmd_ready=1.
REQ-034 rst asserted during STREAM word 4 -> all outputs 0 same cycle, next search completes normally.
REQ-035 cmd_op=00 -> rsp_err=1 with no ctrl activity; add_done during search wait ignored.
